iop_queue: RTL and testbench
============================

Name: iop_queue

Overview:
- Decoupling FIFO between the instruction decoder and the reservation station.
- Buffers decoded internal-operation bundles (iop word, initial station state, pc, 16-bit constant) and presents them on the station's id_ack/id_feed handshake.
- Supports a synchronous flush on control-flow redirect, and reports occupancy for decoder throttling.

Parameters:
- DEPTH, 4, number of bundle entries; power of two, minimum 2.
- CNT_W, 3, occupancy counter width; must equal log2(DEPTH)+1.

Ports:
- clk  in  1  clock
- a_rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous discard of all entries
- dec_valid  in  1  decoder offers a bundle
- dec_ready  out  1  queue accepts a bundle this cycle
- dec_iop  in  32  decoded iop word
- dec_iop_init  in  3  initial station state for the iop
- dec_pc  in  16  pc of the instruction
- dec_k16  in  16  immediate/constant operand
- id_ack  out  1  head bundle valid toward station
- id_iop  out  32  head iop word
- id_iop_init  out  3  head initial state
- id_pc  out  16  head pc
- id_k16  out  16  head constant
- id_feed  in  1  station ready to take head bundle
- q_count  out  CNT_W  entries held
- q_empty  out  1  q_count == 0
- q_full  out  1  q_count == DEPTH

Behaviour:
- Reset values (a_rst high, any time including mid-operation):
  - rd_ptr = wr_ptr = 0; q_count = 0; q_empty = 1; q_full = 0.
  - dec_ready = 1; id_ack = 0; all id_* data outputs = 0.
  - Storage array is not reset.
- Pointers: CNT_W bits each (extra wrap bit); low log2(DEPTH) bits index storage.
  - full when low bits are equal and wrap bits differ; empty when pointers are equal.
- Push: dec_valid & dec_ready & ~flush. Writes the 67-bit bundle at wr_ptr; wr_ptr+1 at the clock edge.
- Pop: id_ack & id_feed. rd_ptr+1 at the clock edge.
- dec_ready = ~q_full & ~flush.
  - No pop-through when full: a push is refused while full even if a pop occurs in the same cycle.
  - Keeps the decoder-to-station path free of combinational loops.
- id_ack = ~q_empty & ~flush.
  - id_* data = entry at rd_ptr when id_ack = 1, else all zeros.
- Latency: a bundle pushed at edge N is visible on id_* in the cycle after edge N (1 cycle).
- Simultaneous push and pop while 0 < q_count < DEPTH: both pointers advance; q_count unchanged.
- q_count is registered: +1 on push-only, -1 on pop-only, unchanged otherwise.
  - Never exceeds DEPTH; never goes below 0.
- Flush (synchronous, highest priority below a_rst):
  - id_ack and dec_ready are forced 0 during the flush cycle, so no transfer occurs.
  - At the edge: rd_ptr = wr_ptr = 0 and q_count = 0.
  - The queue accepts new bundles from the next cycle.
- Wrap-around: pointer increment is modulo 2*DEPTH; ordering is strictly FIFO across the wrap.
- id_feed while empty: no effect. dec_valid while full: bundle held by the decoder, not lost.
- Ordering guarantee: bundles reach the station in push order, none duplicated or dropped except by flush.

Optional Feature:
- Macro IOPQ_BYPASS_EN.
- Defined: when q_empty & ~flush, id_ack = dec_valid and id_* = dec_* combinationally (0-cycle latency).
  - If id_feed = 1 in that cycle, the bundle is consumed directly: not written, pointers and count unchanged.
  - If id_feed = 0, the bundle is pushed normally.
  - dec_ready is unchanged (~q_full & ~flush).
- Undefined: no bypass; minimum latency is 1 cycle as above.

Test Plan:
- Reset then idle -> id_ack=0, q_empty=1, dec_ready=1, id_iop=0x00000000 for 10 cycles.
- Push iop 0x00C00040/pc 0x1000 with id_feed=0, then 3 more (pc 0x1002/4/6) -> q_full=1, dec_ready=0, q_count=4; then id_feed=1 -> pops pc 0x1000,0x1002,0x1004,0x1006 in order, then id_ack=0.
- Continuous push and pop of 12 bundles, pc 0x2000..0x2016 step 2, DEPTH=4 -> every bundle appears once, in order, across two pointer wraps; q_count stays at 1 in steady state.
- q_count=3, assert flush together with dec_valid and id_feed -> no transfer in the flush cycle; next cycle q_count=0, id_ack=0; the following push of pc 0x3000 is at the head one cycle later.
- Assert a_rst mid-stream with q_count=2 -> outputs return to reset values immediately, without waiting for a clock edge.
- IOPQ_BYPASS_EN with queue empty, dec_valid=1, dec_pc=0x4000, id_feed=1 -> same cycle id_ack=1 and id_pc=0x4000; q_count stays 0. Repeat with id_feed=0 -> q_count=1 next cycle.

Source files
------------

// File: rtl/iop_queue.sv
// Decoder-to-station bundle FIFO with flush and occupancy report.
// Optional 0-cycle bypass when empty: define IOPQ_BYPASS_EN.
module iop_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             flush,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [31:0]      dec_iop,
  input  logic [2:0]       dec_iop_init,
  input  logic [15:0]      dec_pc,
  input  logic [15:0]      dec_k16,
  output logic             id_ack,
  output logic [31:0]      id_iop,
  output logic [2:0]       id_iop_init,
  output logic [15:0]      id_pc,
  output logic [15:0]      id_k16,
  input  logic             id_feed,
  output logic [CNT_W-1:0] q_count,
  output logic             q_empty,
  output logic             q_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = 67;

  logic [BW-1:0]    mem [DEPTH];
  logic [CNT_W-1:0] rd_ptr;
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [BW-1:0]    head;
  logic [BW-1:0]    dec_bnd;
  logic [BW-1:0]    out_bnd;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             byp;
  logic             byp_take;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) &&
                 (rd_ptr[AW] != wr_ptr[AW]);

  assign head    = mem[rd_ptr[AW-1:0]];
  assign dec_bnd = {dec_iop, dec_iop_init, dec_pc, dec_k16};

  assign dec_ready = ~full & ~flush;
  assign q_count   = count;
  assign q_empty   = empty;
  assign q_full    = full;

`ifdef IOPQ_BYPASS_EN
  // Empty queue hands the decoder bundle straight to the station.
  assign byp = empty & ~flush;
`else
  assign byp = 1'b0;
`endif

  assign byp_take = byp & dec_valid & id_feed;

  always_comb begin
    id_ack  = 1'b0;
    out_bnd = '0;
    if (byp) begin
      id_ack = dec_valid;
      if (dec_valid) out_bnd = dec_bnd;
    end else if (~empty && ~flush) begin
      id_ack  = 1'b1;
      out_bnd = head;
    end
  end

  assign {id_iop, id_iop_init, id_pc, id_k16} = out_bnd;

  assign push = dec_valid & dec_ready & ~byp_take;
  assign pop  = id_ack & id_feed & ~byp;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= dec_bnd;
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CNT_W'(1);
      if (pop)  rd_ptr <= rd_ptr + CNT_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_iop_queue.sv
// Self-checking bench for iop_queue: vector table plus scoreboard.
// Build with IOPQ_BYPASS_EN defined to cover the bypass path.
module tb_iop_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             a_rst;
  logic             flush;
  logic             dec_valid;
  logic             dec_ready;
  logic [31:0]      dec_iop;
  logic [2:0]       dec_iop_init;
  logic [15:0]      dec_pc;
  logic [15:0]      dec_k16;
  logic             id_ack;
  logic [31:0]      id_iop;
  logic [2:0]       id_iop_init;
  logic [15:0]      id_pc;
  logic [15:0]      id_k16;
  logic             id_feed;
  logic [CNT_W-1:0] q_count;
  logic             q_empty;
  logic             q_full;

  iop_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .a_rst(a_rst), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_iop(dec_iop), .dec_iop_init(dec_iop_init),
    .dec_pc(dec_pc), .dec_k16(dec_k16),
    .id_ack(id_ack), .id_iop(id_iop),
    .id_iop_init(id_iop_init), .id_pc(id_pc),
    .id_k16(id_k16), .id_feed(id_feed),
    .q_count(q_count), .q_empty(q_empty), .q_full(q_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] iop;
    logic [2:0]  init;
    logic [15:0] pc;
    logic [15:0] k16;
  } bnd_t;

  typedef struct {
    logic        dv;
    logic [15:0] pc;
    logic        fd;
    logic        fl;
    int          cnt;
    logic        full;
    logic        ready;
  } vec_t;

  bnd_t sb[$];
  int   total  = 0;
  int   passed = 0;

  function automatic bnd_t mk(input logic [15:0] pc);
    bnd_t b;
    b.iop  = 32'h00C00040 + 32'(pc) - 32'h1000;
    b.init = pc[3:1];
    b.pc   = pc;
    b.k16  = ~pc;
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle's inputs, check against the model, update the model.
  task automatic drive(input logic dv, input logic [15:0] pc,
                       input logic fd, input logic fl);
    bnd_t b;
    bnd_t e;
    int   n;
    logic byp;
    logic m_ack;
    logic m_rdy;
    @(negedge clk);
    b = mk(pc);
    dec_valid    = dv;
    dec_iop      = b.iop;
    dec_iop_init = b.init;
    dec_pc       = b.pc;
    dec_k16      = b.k16;
    id_feed      = fd;
    flush        = fl;
    #1;
    n   = sb.size();
    byp = 1'b0;
`ifdef IOPQ_BYPASS_EN
    byp = (n == 0) && !fl;
`endif
    m_rdy = (n < DEPTH) && !fl;
    m_ack = byp ? dv : ((n > 0) && !fl);
    e = '{32'h0, 3'h0, 16'h0, 16'h0};
    if (m_ack) e = byp ? b : sb[0];
    chk("dec_ready", 32'(dec_ready), 32'(m_rdy));
    chk("id_ack",    32'(id_ack),    32'(m_ack));
    chk("q_count",   32'(q_count),   32'(n));
    chk("q_empty",   32'(q_empty),   32'(n == 0));
    chk("id_bundle", {id_iop[15:0], id_pc}, {e.iop[15:0], e.pc});
    chk("id_meta",   {13'h0, id_iop_init, id_k16},
                     {13'h0, e.init, e.k16});
    if (fl) sb.delete();
    else begin
      if (!byp && m_ack && fd) void'(sb.pop_front());
      if (dv && m_rdy && !(byp && fd)) sb.push_back(b);
    end
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 16'h1000, 1'b0, 1'b0, 0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 16'h1002, 1'b0, 1'b0, 1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 16'h1004, 1'b0, 1'b0, 2, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 16'h1006, 1'b0, 1'b0, 3, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 16'h1008, 1'b0, 1'b0, 4, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 1'b1};

    a_rst = 1'b1;
    flush = 1'b0;
    dec_valid = 1'b0;
    dec_iop = '0;
    dec_iop_init = '0;
    dec_pc = '0;
    dec_k16 = '0;
    id_feed = 1'b0;
    #2;
    chk("rst_count", 32'(q_count), 32'd0);
    chk("rst_empty", 32'(q_empty), 32'd1);
    chk("rst_full",  32'(q_full),  32'd0);
    chk("rst_ready", 32'(dec_ready), 32'd1);
    chk("rst_ack",   32'(id_ack),  32'd0);
    @(negedge clk);
    a_rst = 1'b0;

    for (int i = 0; i < 10; i++) drive(1'b0, 16'h0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].dv, tbl[i].pc, tbl[i].fd, tbl[i].fl);
      chk($sformatf("tbl%0d_cnt", i), 32'(q_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_full", i), 32'(q_full), 32'(tbl[i].full));
      chk($sformatf("tbl%0d_rdy", i), 32'(dec_ready), 32'(tbl[i].ready));
    end

    // Streaming through two pointer wraps.
    for (int i = 0; i < 12; i++)
      drive(1'b1, 16'h2000 + 16'(2 * i), 1'b1, 1'b0);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk("stream_drained", 32'(q_count), 32'd0);

    // Flush with a push and a pop offered in the same cycle.
    drive(1'b1, 16'h2100, 1'b0, 1'b0);
    drive(1'b1, 16'h2102, 1'b0, 1'b0);
    drive(1'b1, 16'h2104, 1'b0, 1'b0);
    drive(1'b1, 16'h2106, 1'b1, 1'b1);
    chk("flush_no_ack", 32'(id_ack), 32'd0);
    chk("flush_no_rdy", 32'(dec_ready), 32'd0);
    drive(1'b1, 16'h3000, 1'b0, 1'b0);
    chk("post_flush_cnt", 32'(q_count), 32'd0);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    chk("head_3000", 32'(id_pc), 32'h3000);
    drive(1'b0, 16'h0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream.
    drive(1'b1, 16'h5000, 1'b0, 1'b0);
    drive(1'b1, 16'h5002, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    a_rst = 1'b1;
    #1;
    chk("arst_count", 32'(q_count), 32'd0);
    chk("arst_empty", 32'(q_empty), 32'd1);
    chk("arst_ack",   32'(id_ack),  32'd0);
    chk("arst_iop",   id_iop,       32'd0);
    sb.delete();
    @(negedge clk);
    a_rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);

`ifdef IOPQ_BYPASS_EN
    drive(1'b1, 16'h4000, 1'b1, 1'b0);
    chk("byp_pc", 32'(id_pc), 32'h4000);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk("byp_cnt0", 32'(q_count), 32'd0);
    drive(1'b1, 16'h4002, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk("byp_cnt1", 32'(q_count), 32'd1);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
